// File: rtl/axi_stream_master.sv
// -----------------------------------------------------------------------------
// axi_stream_master
//
// AXI4-Stream transmitter. A simple write port pushes words into a circular
// FIFO, and an output register presents them on the m00_axis master port with
// a tvalid/tready handshake and tlast framing. The block also counts completed
// beats and completed frames.
//
// Optional build macro:
//   AXIS_MASTER_AUTOLAST_EN  - when defined, wr_last is ignored and tlast is
//                              generated internally on every PKT_WORDS-th beat
//                              launched. When undefined, tlast is the wr_last
//                              bit stored with each word.
//
// Ports:
//   m00_axis_aclk     in   clock, rising edge
//   m00_axis_areset   in   asynchronous active-high reset
//   tx_en             in   transmit enable (gates launching of new beats)
//   wr_en             in   push request
//   wr_data           in   word to push
//   wr_last           in   pushed word closes a packet
//   full              out  FIFO full
//   empty             out  FIFO empty (output register excluded)
//   level             out  words held in the FIFO (output register excluded)
//   overflow          out  sticky: a push was attempted while full
//   m00_axis_tvalid   out  beat valid
//   m00_axis_tready   in   sink ready
//   m00_axis_tdata    out  beat data
//   m00_axis_tstrb    out  byte strobes (all ones while tvalid)
//   m00_axis_tlast    out  last beat of packet
//   beat_cnt          out  completed handshakes (wraps)
//   frame_cnt         out  completed handshakes with tlast=1 (wraps)
// -----------------------------------------------------------------------------
module axi_stream_master #(
    parameter int C_M_AXIS_TDATA_WIDTH = 32,
    parameter int FIFO_SIZE            = 2048,
    parameter int PKT_WORDS            = 4
) (
    input  logic                                m00_axis_aclk,
    input  logic                                m00_axis_areset,
    input  logic                                tx_en,
    input  logic                                wr_en,
    input  logic [C_M_AXIS_TDATA_WIDTH-1:0]     wr_data,
    input  logic                                wr_last,
    output logic                                full,
    output logic                                empty,
    output logic [$clog2(FIFO_SIZE):0]          level,
    output logic                                overflow,
    output logic                                m00_axis_tvalid,
    input  logic                                m00_axis_tready,
    output logic [C_M_AXIS_TDATA_WIDTH-1:0]     m00_axis_tdata,
    output logic [C_M_AXIS_TDATA_WIDTH/8-1:0]   m00_axis_tstrb,
    output logic                                m00_axis_tlast,
    output logic [31:0]                         beat_cnt,
    output logic [31:0]                         frame_cnt
);

    localparam int W      = C_M_AXIS_TDATA_WIDTH;
    localparam int AW     = $clog2(FIFO_SIZE);
    localparam int STRB_W = W / 8;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_SEND = 1'b1
    } state_t;

    // -------------------------------------------------------------------------
    // FIFO storage and pointers
    // -------------------------------------------------------------------------
    // Each entry holds {last, data}. Pointers carry one extra wrap bit so that
    // full and empty can be told apart when the index bits match.
    logic [W:0]  mem [FIFO_SIZE];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;

    logic        push;
    logic        load;
    logic        handshake;
    logic [W:0]  head;

    state_t      state;
    state_t      state_nxt;

    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty = (wr_ptr == rd_ptr);
    assign level = wr_ptr - rd_ptr;
    assign head  = mem[rd_ptr[AW-1:0]];

    // full is the pre-edge value, so a push alongside a pop while full is
    // still rejected.
    assign push = wr_en && !full;

    // The output register may be refilled when it is empty or when its
    // current beat is being accepted in this same cycle.
    assign m00_axis_tvalid = (state == S_SEND);
    assign load            = tx_en && !empty && (!m00_axis_tvalid || m00_axis_tready);
    assign handshake       = m00_axis_tvalid && m00_axis_tready;
    assign m00_axis_tstrb  = {STRB_W{m00_axis_tvalid}};

    // NOTE: the storage array is deliberately not reset; emptiness is defined
    // by the pointers alone, and leaving the RAM out of reset lets it map onto
    // memory primitives.
    always_ff @(posedge m00_axis_aclk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= {wr_last, wr_data};
        end
    end

    // NOTE: clocked state is updated with non-blocking assignments so every
    // register samples pre-edge values regardless of block ordering.
    always_ff @(posedge m00_axis_aclk or posedge m00_axis_areset) begin
        if (m00_axis_areset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (load) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (wr_en && full) begin
                overflow <= 1'b1;
            end
        end
    end

    // -------------------------------------------------------------------------
    // tlast source
    // -------------------------------------------------------------------------
    logic next_last;

`ifdef AXIS_MASTER_AUTOLAST_EN
    localparam int PCW = (PKT_WORDS > 1) ? $clog2(PKT_WORDS) : 1;

    logic [PCW-1:0] pkt_cnt;
    logic           pkt_end;
    logic           unused_head_last;

    // The stored last bit is still written but has no consumer in this mode.
    assign unused_head_last = head[W];
    assign pkt_end          = (pkt_cnt == PCW'(PKT_WORDS - 1));
    assign next_last        = pkt_end;

    // Beat position within the packet, advanced once per launched beat.
    always_ff @(posedge m00_axis_aclk or posedge m00_axis_areset) begin
        if (m00_axis_areset) begin
            pkt_cnt <= '0;
        end else if (load) begin
            pkt_cnt <= pkt_end ? '0 : pkt_cnt + 1'b1;
        end
    end
`else
    localparam int UNUSED_PKT_WORDS = PKT_WORDS;

    assign next_last = head[W];
`endif

    // -------------------------------------------------------------------------
    // Output register FSM
    // -------------------------------------------------------------------------
    always_ff @(posedge m00_axis_aclk or posedge m00_axis_areset) begin
        if (m00_axis_areset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: state_nxt gets its default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                // tready is ignored while nothing is presented.
                if (load) begin
                    state_nxt = S_SEND;
                end
            end
            S_SEND: begin
                // Without a handshake the beat is held, even if tx_en drops.
                if (m00_axis_tready && !load) begin
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Data and tlast only change on a load, so both hold stable during a stall.
    always_ff @(posedge m00_axis_aclk or posedge m00_axis_areset) begin
        if (m00_axis_areset) begin
            m00_axis_tdata <= '0;
            m00_axis_tlast <= 1'b0;
        end else if (load) begin
            m00_axis_tdata <= head[W-1:0];
            m00_axis_tlast <= next_last;
        end
    end

    // -------------------------------------------------------------------------
    // Beat / frame counters (wrap modulo 2^32)
    // -------------------------------------------------------------------------
    always_ff @(posedge m00_axis_aclk or posedge m00_axis_areset) begin
        if (m00_axis_areset) begin
            beat_cnt  <= '0;
            frame_cnt <= '0;
        end else if (handshake) begin
            beat_cnt <= beat_cnt + 32'd1;
            if (m00_axis_tlast) begin
                frame_cnt <= frame_cnt + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_axi_stream_master.sv
// -----------------------------------------------------------------------------
// tb_axi_stream_master
//
// Self-checking bench for axi_stream_master. A cycle table covers the basic
// 8-word, two-packet stream; hand-written sequences cover stalls, overflow,
// random back-pressure, asynchronous reset mid-packet and (when built with
// AXIS_MASTER_AUTOLAST_EN) internal tlast generation.
// -----------------------------------------------------------------------------
module tb_axi_stream_master;

    localparam int W         = 32;
    localparam int DEPTH     = 2048;
    localparam int PKT       = 4;
    localparam int LW        = $clog2(DEPTH) + 1;

    logic           aclk;
    logic           areset;
    logic           tx_en;
    logic           wr_en;
    logic [W-1:0]   wr_data;
    logic           wr_last;
    logic           full;
    logic           empty;
    logic [LW-1:0]  level;
    logic           overflow;
    logic           tvalid;
    logic           tready;
    logic [W-1:0]   tdata;
    logic [W/8-1:0] tstrb;
    logic           tlast;
    logic [31:0]    beat_cnt;
    logic [31:0]    frame_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    axi_stream_master #(
        .C_M_AXIS_TDATA_WIDTH (W),
        .FIFO_SIZE            (DEPTH),
        .PKT_WORDS            (PKT)
    ) dut (
        .m00_axis_aclk   (aclk),
        .m00_axis_areset (areset),
        .tx_en           (tx_en),
        .wr_en           (wr_en),
        .wr_data         (wr_data),
        .wr_last         (wr_last),
        .full            (full),
        .empty           (empty),
        .level           (level),
        .overflow        (overflow),
        .m00_axis_tvalid (tvalid),
        .m00_axis_tready (tready),
        .m00_axis_tdata  (tdata),
        .m00_axis_tstrb  (tstrb),
        .m00_axis_tlast  (tlast),
        .beat_cnt        (beat_cnt),
        .frame_cnt       (frame_cnt)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    typedef struct {
        logic        tx_en;
        logic        wr_en;
        logic [31:0] wr_data;
        logic        wr_last;
        logic        tready;
        logic        e_tvalid;
        logic [31:0] e_tdata;
        logic        e_tlast;
        int          e_level;
        int          e_beat;
        int          e_frame;
    } vec_t;

    vec_t vecs[10];

    function automatic vec_t mk(input logic te, input logic we, input logic [31:0] wd,
                                input logic wl, input logic tr, input logic ev,
                                input logic [31:0] ed, input logic el, input int lv,
                                input int bc, input int fc);
        vec_t v;
        v.tx_en = te; v.wr_en = we; v.wr_data = wd; v.wr_last = wl; v.tready = tr;
        v.e_tvalid = ev; v.e_tdata = ed; v.e_tlast = el; v.e_level = lv;
        v.e_beat = bc; v.e_frame = fc;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge aclk);
        areset  = 1'b1;
        tx_en   = 1'b0;
        wr_en   = 1'b0;
        wr_data = '0;
        wr_last = 1'b0;
        tready  = 1'b0;
        repeat (2) @(negedge aclk);
        areset = 1'b0;
    endtask

    initial begin
        int got;
        int idx;
        int exp_w;
        logic prev_stall;
        logic [31:0] prev_data;

        areset  = 1'b1;
        tx_en   = 1'b0;
        wr_en   = 1'b0;
        wr_data = '0;
        wr_last = 1'b0;
        tready  = 1'b0;
        repeat (2) @(negedge aclk);
        areset = 1'b0;

        // ---------------- reset state ----------------
        check("rst tvalid", 64'(tvalid), 64'd0);
        check("rst tdata", 64'(tdata), 64'd0);
        check("rst tstrb", 64'(tstrb), 64'd0);
        check("rst tlast", 64'(tlast), 64'd0);
        check("rst level", 64'(level), 64'd0);
        check("rst empty", 64'(empty), 64'd1);
        check("rst full", 64'(full), 64'd0);
        check("rst overflow", 64'(overflow), 64'd0);
        check("rst beat_cnt", 64'(beat_cnt), 64'd0);
        check("rst frame_cnt", 64'(frame_cnt), 64'd0);

        // ---------------- test 1: 8 words, two packets, tready=1 ----------------
        // Expected values are the state just after each edge.
        vecs[0] = mk(1, 1, 32'd1, 0, 1, 0, 32'd0, 0, 1, 0, 0);
        vecs[1] = mk(1, 1, 32'd2, 0, 1, 1, 32'd1, 0, 1, 0, 0);
        vecs[2] = mk(1, 1, 32'd3, 0, 1, 1, 32'd2, 0, 1, 1, 0);
        vecs[3] = mk(1, 1, 32'd4, 1, 1, 1, 32'd3, 0, 1, 2, 0);
        vecs[4] = mk(1, 1, 32'd5, 0, 1, 1, 32'd4, 1, 1, 3, 0);
        vecs[5] = mk(1, 1, 32'd6, 0, 1, 1, 32'd5, 0, 1, 4, 1);
        vecs[6] = mk(1, 1, 32'd7, 0, 1, 1, 32'd6, 0, 1, 5, 1);
        vecs[7] = mk(1, 1, 32'd8, 1, 1, 1, 32'd7, 0, 1, 6, 1);
        vecs[8] = mk(1, 0, 32'd0, 0, 1, 1, 32'd8, 1, 0, 7, 1);
        vecs[9] = mk(1, 0, 32'd0, 0, 1, 0, 32'd8, 1, 0, 8, 2);

        for (int i = 0; i < 10; i++) begin
            @(negedge aclk);
            tx_en   = vecs[i].tx_en;
            wr_en   = vecs[i].wr_en;
            wr_data = vecs[i].wr_data;
            wr_last = vecs[i].wr_last;
            tready  = vecs[i].tready;
            @(posedge aclk);
            #1;
            check($sformatf("t1[%0d] tvalid", i), 64'(tvalid), 64'(vecs[i].e_tvalid));
            check($sformatf("t1[%0d] tstrb", i), 64'(tstrb), vecs[i].e_tvalid ? 64'hF : 64'h0);
            if (vecs[i].e_tvalid) begin
                check($sformatf("t1[%0d] tdata", i), 64'(tdata), 64'(vecs[i].e_tdata));
                check($sformatf("t1[%0d] tlast", i), 64'(tlast), 64'(vecs[i].e_tlast));
            end
            check($sformatf("t1[%0d] level", i), 64'(level), 64'(vecs[i].e_level));
            check($sformatf("t1[%0d] beat_cnt", i), 64'(beat_cnt), 64'(vecs[i].e_beat));
            check($sformatf("t1[%0d] frame_cnt", i), 64'(frame_cnt), 64'(vecs[i].e_frame));
        end
        check("t1 empty", 64'(empty), 64'd1);

        // ---------------- test 2: stall with tready=0 ----------------
        do_reset();
        tx_en   = 1'b1;
        tready  = 1'b0;
        wr_en   = 1'b1;
        wr_data = 32'hDEAD_BEEF;
        @(negedge aclk);
        wr_en = 1'b0;
        check("t2 tvalid after push edge", 64'(tvalid), 64'd0);
        @(negedge aclk);
        check("t2 tvalid after load", 64'(tvalid), 64'd1);
        check("t2 tdata after load", 64'(tdata), 64'hDEAD_BEEF);
        for (int c = 0; c < 5; c++) begin
            // Dropping tx_en mid-stall must not retract the pending beat.
            tx_en = (c == 2 || c == 3) ? 1'b0 : 1'b1;
            @(negedge aclk);
            check($sformatf("t2 stall%0d tvalid", c), 64'(tvalid), 64'd1);
            check($sformatf("t2 stall%0d tdata", c), 64'(tdata), 64'hDEAD_BEEF);
            check($sformatf("t2 stall%0d tstrb", c), 64'(tstrb), 64'hF);
            check($sformatf("t2 stall%0d beat_cnt", c), 64'(beat_cnt), 64'd0);
        end
        tx_en  = 1'b1;
        tready = 1'b1;
        @(negedge aclk);
        check("t2 tvalid after handshake", 64'(tvalid), 64'd0);
        check("t2 beat_cnt", 64'(beat_cnt), 64'd1);
        check("t2 frame_cnt", 64'(frame_cnt), 64'd0);
        @(negedge aclk);
        check("t2 beat_cnt idle tready", 64'(beat_cnt), 64'd1);

        // ---------------- test 3: fill, overflow, drain ----------------
        do_reset();
        tx_en  = 1'b0;
        tready = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            wr_en   = 1'b1;
            wr_data = 32'h1000_0000 + 32'(i);
            @(negedge aclk);
        end
        check("t3 full", 64'(full), 64'd1);
        check("t3 level full", 64'(level), 64'(DEPTH));
        check("t3 overflow before", 64'(overflow), 64'd0);
        wr_data = 32'hFFFF_FFFF;
        @(negedge aclk);
        check("t3 overflow", 64'(overflow), 64'd1);
        check("t3 level after drop", 64'(level), 64'(DEPTH));
        check("t3 tvalid held off", 64'(tvalid), 64'd0);
        // Push and pop on the same edge while full: push must be rejected.
        tx_en   = 1'b1;
        wr_data = 32'hEEEE_EEEE;
        @(negedge aclk);
        wr_en = 1'b0;
        check("t3 level push+pop full", 64'(level), 64'(DEPTH - 1));
        check("t3 full cleared", 64'(full), 64'd0);
        check("t3 overflow sticky", 64'(overflow), 64'd1);
        got = 0;
        for (int c = 0; c < DEPTH + 50; c++) begin
            if (tvalid) begin
                check($sformatf("t3 beat%0d tdata", got), 64'(tdata), 64'(32'h1000_0000 + 32'(got)));
                got++;
            end
            @(negedge aclk);
        end
        check("t3 beats out", 64'(got), 64'(DEPTH));
        check("t3 empty end", 64'(empty), 64'd1);
        check("t3 level end", 64'(level), 64'd0);
        check("t3 beat_cnt", 64'(beat_cnt), 64'(DEPTH));

        // ---------------- test 4: random back-pressure ----------------
        do_reset();
        tx_en      = 1'b1;
        idx        = 0;
        exp_w      = 0;
        prev_stall = 1'b0;
        prev_data  = '0;
        for (int c = 0; c < 2000 && exp_w < 100; c++) begin
            @(negedge aclk);
            if (prev_stall) begin
                check("t4 stall tvalid", 64'(tvalid), 64'd1);
                check("t4 stall tdata", 64'(tdata), 64'(prev_data));
            end
            wr_en   = (idx < 100);
            wr_data = 32'(idx);
            wr_last = 1'b0;
            if (idx < 100) idx++;
            tready = 1'($urandom_range(0, 1));
            if (tvalid && tready) begin
                check($sformatf("t4 word%0d", exp_w), 64'(tdata), 64'(exp_w));
                exp_w++;
            end
            prev_stall = tvalid && !tready;
            prev_data  = tdata;
        end
        check("t4 words received", 64'(exp_w), 64'd100);

        // ---------------- test 5: async reset mid-packet ----------------
        do_reset();
        tx_en   = 1'b1;
        tready  = 1'b0;
        wr_en   = 1'b1;
        wr_data = 32'hA;
        @(negedge aclk);
        wr_data = 32'hB;
        @(negedge aclk);
        wr_data = 32'hC;
        @(negedge aclk);
        wr_en  = 1'b0;
        tready = 1'b1;
        @(negedge aclk);
        tready = 1'b0;
        check("t5 pre tvalid", 64'(tvalid), 64'd1);
        check("t5 pre tdata", 64'(tdata), 64'hB);
        check("t5 pre beat_cnt", 64'(beat_cnt), 64'd1);
        check("t5 pre level", 64'(level), 64'd1);
        #2;
        areset = 1'b1;
        #1;
        check("t5 async tvalid", 64'(tvalid), 64'd0);
        check("t5 async tstrb", 64'(tstrb), 64'd0);
        check("t5 async level", 64'(level), 64'd0);
        check("t5 async empty", 64'(empty), 64'd1);
        check("t5 async beat_cnt", 64'(beat_cnt), 64'd0);
        check("t5 async frame_cnt", 64'(frame_cnt), 64'd0);
        @(negedge aclk);
        areset  = 1'b0;
        tready  = 1'b1;
        wr_en   = 1'b1;
        wr_data = 32'h1234_5678;
        @(negedge aclk);
        wr_en = 1'b0;
        check("t5 post push tvalid", 64'(tvalid), 64'd0);
        check("t5 post push level", 64'(level), 64'd1);
        @(negedge aclk);
        check("t5 post tvalid", 64'(tvalid), 64'd1);
        check("t5 post tdata", 64'(tdata), 64'h1234_5678);
        check("t5 post tlast", 64'(tlast), 64'd0);
        @(negedge aclk);
        check("t5 post handshake tvalid", 64'(tvalid), 64'd0);
        check("t5 post beat_cnt", 64'(beat_cnt), 64'd1);

`ifdef AXIS_MASTER_AUTOLAST_EN
        // ---------------- test 6: internal tlast every PKT beats ----------------
        do_reset();
        tx_en  = 1'b1;
        tready = 1'b1;
        idx    = 0;
        got    = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge aclk);
            if (tvalid) begin
                check($sformatf("t6 beat%0d tdata", got), 64'(tdata), 64'(32'd100 + 32'(got)));
                check($sformatf("t6 beat%0d tlast", got), 64'(tlast), 64'((got % PKT) == PKT - 1));
                got++;
            end
            wr_en   = (idx < 12);
            wr_data = 32'd100 + 32'(idx);
            wr_last = 1'b0;
            if (idx < 12) idx++;
        end
        check("t6 beats", 64'(got), 64'd12);
        check("t6 frame_cnt", 64'(frame_cnt), 64'd3);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
